turbo_halfiter_seq_ctrl: RTL and testbench

// - Sequences the turbo-decoder read-address calculator across half-iterations.
// - Per iteration: half 0 (linear, decMode=0), then half 1 (QPP-interleaved, decMode=1).
// - Per half: one Init_flag pulse with start values, blockSize address cycles, then a drain gap for the SISO pipeline.
// - Sits between the decoder top-level control and the read-address calculator; counts iterations and honours early stop.

---
 rtl/turbo_dec_pkg.sv | 18 +
 rtl/turbo_seq_cnt.sv | 25 ++
 rtl/turbo_halfiter_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_turbo_halfiter_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_dec_pkg.sv
// Shared turbo-decoder definitions: sequencer state encoding and address/Q-vector sizes.
package turbo_dec_pkg;

    localparam int AW       = 13;   // mirrors `Data_Addr_width
    localparam int ITER_W   = 4;
    localparam int QF_LANES = 8;
    localparam int QF_W     = 3;
    localparam int QF_VEC_W = QF_LANES * QF_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/turbo_seq_cnt.sv
// Loadable terminal-count counter: counts 0..term while enabled, wraps to 0 after term.
module turbo_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    assign at_term = (cnt == term);

    // Count register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_term ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/turbo_halfiter_seq_ctrl.sv
// Half-iteration sequencer for the turbo-decoder read-address calculator.
// Handshake: a request is taken on a cycle where start=1 and ready=1 (ready is high
// only in IDLE); start at any other time is ignored, and abort on the same cycle wins.
module turbo_halfiter_seq_ctrl #(
    parameter int AW        = 13,
    parameter int ITER_W    = 4,
    parameter int DRAIN_CYC = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [AW-1:0]                        cfg_blk,
    input  logic [ITER_W-1:0]                    cfg_maxIter,
    input  logic [AW-1:0]                        cfg_RfInit,
    input  logic [turbo_dec_pkg::QF_VEC_W-1:0]   cfg_QfInit,
    input  logic                                 early_stop,
    output logic                                 ready,
    output logic                                 Init_flag,
    output logic                                 decMode,
    output logic [AW-1:0]                        blockSize,
    output logic [AW-1:0]                        Req_A_Init,
    output logic [AW+turbo_dec_pkg::QF_VEC_W-1:0] Req_RQ_Init,
    output logic                                 rd_valid,
    output logic [AW-1:0]                        addr_cnt,
    output logic [ITER_W-1:0]                    iter_cnt,
    output logic                                 done,
    output logic                                 cfg_err,
    output logic [2:0]                           dbg_state
);

    import turbo_dec_pkg::*;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_TERM = DW'(DRAIN_CYC - 1);

    seq_state_t              state_q, state_d;
    logic                    half_q, half_d;
    logic                    stop_q, stop_d, stop_now;
    logic [ITER_W-1:0]       iter_d;
    logic [ITER_W-1:0]       max_iter_q;
    logic [AW-1:0]           rf_q;
    logic [QF_VEC_W-1:0]     qf_q;
    logic                    latch_cfg, cfg_err_d;
    logic [ITER_W:0]         iter_inc, max_eff;
    logic [AW-1:0]           addr_term;
    logic                    addr_at_term, drain_at_term;
    logic [DW-1:0]           drain_cnt;

    assign Req_A_Init  = '0;
    assign Req_RQ_Init = {rf_q, qf_q};
    assign addr_term   = blockSize - AW'(1);
    assign dbg_state   = state_q;

    turbo_seq_cnt #(.W(AW)) u_addr_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (abort || (state_q != ST_RUN)),
        .en      (state_q == ST_RUN),
        .term    (addr_term),
        .cnt     (addr_cnt),
        .at_term (addr_at_term)
    );

    turbo_seq_cnt #(.W(DW)) u_drain_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (abort || (state_q != ST_DRAIN)),
        .en      (state_q == ST_DRAIN),
        .term    (DRAIN_TERM),
        .cnt     (drain_cnt),
        .at_term (drain_at_term)
    );

    // Next-state, half/iteration bookkeeping and sticky early-stop flag.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        iter_d    = iter_cnt;
        latch_cfg = 1'b0;
        cfg_err_d = 1'b0;
        iter_inc  = {1'b0, iter_cnt} + (ITER_W+1)'(1);
        max_eff   = (max_iter_q == '0) ? (ITER_W+1)'(1) : {1'b0, max_iter_q};
        stop_now  = stop_q | (early_stop & half_q &
                              ((state_q == ST_RUN) || (state_q == ST_DRAIN)));
        stop_d    = stop_now;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_blk != '0) begin
                        latch_cfg = 1'b1;
                        half_d    = 1'b0;
                        iter_d    = '0;
                        stop_d    = 1'b0;
                        state_d   = ST_INIT;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (addr_at_term) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_at_term) begin
                    if (!half_q) begin
                        half_d  = 1'b1;
                        state_d = ST_INIT;
                    end else begin
                        iter_d = iter_inc[ITER_W-1:0];
                        if (stop_now || (iter_inc >= max_eff)) begin
                            state_d = ST_DONE;
                        end else begin
                            half_d  = 1'b0;
                            stop_d  = 1'b0;
                            state_d = ST_INIT;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            half_d    = half_q;
            iter_d    = iter_cnt;
            stop_d    = stop_q;
            latch_cfg = 1'b0;
            cfg_err_d = 1'b0;
        end
    end

    // State, latched configuration and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            half_q     <= 1'b0;
            stop_q     <= 1'b0;
            iter_cnt   <= '0;
            max_iter_q <= '0;
            blockSize  <= '0;
            rf_q       <= '0;
            qf_q       <= '0;
            ready      <= 1'b1;
            Init_flag  <= 1'b0;
            decMode    <= 1'b0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            stop_q    <= stop_d;
            iter_cnt  <= iter_d;
            if (latch_cfg) begin
                blockSize  <= cfg_blk;
                max_iter_q <= cfg_maxIter;
                rf_q       <= cfg_RfInit;
                qf_q       <= cfg_QfInit;
            end
            ready     <= (state_d == ST_IDLE);
            Init_flag <= (state_d == ST_INIT);
            rd_valid  <= (state_d == ST_RUN);
            done      <= (state_d == ST_DONE);
            cfg_err   <= cfg_err_d;
            if (state_d == ST_INIT) decMode <= half_d;
        end
    end

endmodule

// File: tb/tb_turbo_halfiter_seq_ctrl.sv
// Bench for turbo_halfiter_seq_ctrl: per-cycle trace model of whole decode runs.
module tb_turbo_halfiter_seq_ctrl;

    localparam int AW    = 13;
    localparam int IW    = 4;
    localparam int QW    = 24;
    localparam int DRAIN = 6;
    localparam int VW    = 4 + AW + 2 + IW;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [AW-1:0]     cfg_blk = '0;
    logic [IW-1:0]     cfg_maxIter = '0;
    logic [AW-1:0]     cfg_RfInit = '0;
    logic [QW-1:0]     cfg_QfInit = '0;
    logic              early_stop = 1'b0;
    logic              ready, Init_flag, decMode, rd_valid, done, cfg_err;
    logic [AW-1:0]     blockSize, Req_A_Init, addr_cnt;
    logic [AW+QW-1:0]  Req_RQ_Init;
    logic [IW-1:0]     iter_cnt;
    logic [2:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    turbo_halfiter_seq_ctrl #(.AW(AW), .ITER_W(IW), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_blk(cfg_blk), .cfg_maxIter(cfg_maxIter), .cfg_RfInit(cfg_RfInit),
        .cfg_QfInit(cfg_QfInit), .early_stop(early_stop), .ready(ready),
        .Init_flag(Init_flag), .decMode(decMode), .blockSize(blockSize),
        .Req_A_Init(Req_A_Init), .Req_RQ_Init(Req_RQ_Init), .rd_valid(rd_valid),
        .addr_cnt(addr_cnt), .iter_cnt(iter_cnt), .done(done), .cfg_err(cfg_err),
        .dbg_state(dbg_state)
    );

    function automatic logic [VW-1:0] mk(input int r, input int ini, input int dec,
                                          input int rv, input int addr, input int dn,
                                          input int it);
        mk = {r[0], ini[0], dec[0], rv[0], AW'(addr), dn[0], 1'b0, IW'(it)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        dut_vec = {ready, Init_flag, decMode, rd_valid, addr_cnt, done, cfg_err, iter_cnt};
    endfunction

    // scoreboard: full decode run against an expected per-cycle trace
    task automatic run_seq(input string name, input int blk, input int mi,
                           input int es_iter, input int es_half, input int es_addr,
                           input int noise_idx);
        logic [VW-1:0] exp_q[$];
        logic [VW-1:0] exp_v, got;
        logic [AW-1:0] rf;
        logic [QW-1:0] qf;
        int es_idx = -1;
        int it = 0;
        int eff;
        bit stop = 0;
        bit fin = 0;
        eff = (mi == 0) ? 1 : mi;
        while (!fin) begin
            for (int h = 0; h < 2; h++) begin
                exp_q.push_back(mk(0, 1, h, 0, 0, 0, it));
                for (int a = 0; a < blk; a++) begin
                    if (it == es_iter && h == es_half && a == es_addr) begin
                        es_idx = exp_q.size();
                        if (h == 1) stop = 1;
                    end
                    exp_q.push_back(mk(0, 0, h, 1, a, 0, it));
                end
                for (int d = 0; d < DRAIN; d++) exp_q.push_back(mk(0, 0, h, 0, 0, 0, it));
            end
            it++;
            if (stop || it >= eff) fin = 1;
        end
        exp_q.push_back(mk(0, 0, 1, 0, 0, 1, it));
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0, it));

        rf = AW'($urandom);
        qf = QW'($urandom);
        cfg_blk = AW'(blk); cfg_maxIter = IW'(mi); cfg_RfInit = rf; cfg_QfInit = qf;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            exp_v = exp_q.pop_front();
            got = dut_vec();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", name, i, got, exp_v);
            end
            early_stop = (i == es_idx);
            if (i == noise_idx) begin
                start = 1'b1;
                cfg_blk = AW'($urandom_range(1, 100));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        early_stop = 1'b0;
        start = 1'b0;
        total++;
        if (blockSize !== AW'(blk) || Req_RQ_Init !== {rf, qf} || Req_A_Init !== '0) begin
            bad++;
            $display("FAIL %s_cfg blk=%0d rq=%h a=%0d exp_blk=%0d exp_rq=%h",
                     name, blockSize, Req_RQ_Init, Req_A_Init, blk, {rf, qf});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (dut_vec() !== mk(1, 0, 0, 0, 0, 0, 0) || blockSize !== '0 ||
            Req_RQ_Init !== '0 || Req_A_Init !== '0) begin
            bad++;
            $display("FAIL reset got=%h exp=%h blk=%0d", dut_vec(), mk(1, 0, 0, 0, 0, 0, 0), blockSize);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (dut_vec() !== mk(1, 0, 0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec(), mk(1, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_basic_timing();
        int cyc = 0, inits = 0, valids = 0, done_at = -1;
        logic [3:0] modes = '0;
        cfg_blk = 40; cfg_maxIter = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_at < 0 && cyc < 400) begin
            cyc++;
            if (Init_flag) begin
                if (inits < 4) modes[inits] = decMode;
                inits++;
            end
            if (rd_valid) valids++;
            if (done) done_at = cyc;
            @(negedge clk);
        end
        total++;
        if (done_at !== 4 * (1 + 40 + DRAIN) + 1) begin
            bad++;
            $display("FAIL done_cycle got=%0d exp=%0d", done_at, 4 * (1 + 40 + DRAIN) + 1);
        end
        total++;
        if (inits !== 4 || modes !== 4'b1010) begin
            bad++;
            $display("FAIL init_pulses got=%0d modes=%b exp=4 modes=1010", inits, modes);
        end
        total++;
        if (valids !== 160 || iter_cnt !== 4'd2) begin
            bad++;
            $display("FAIL valid_iter got=%0d/%0d exp=160/2", valids, iter_cnt);
        end
    endtask

    task automatic test_cfg_err();
        cfg_blk = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (cfg_err !== 1'b1 || ready !== 1'b1 || Init_flag !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err got=%b ready=%b init=%b exp=1 1 0", cfg_err, ready, Init_flag);
        end
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b0 || ready !== 1'b1 || Init_flag !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_pulse got=%b ready=%b init=%b exp=0 1 0", cfg_err, ready, Init_flag);
        end
        // abort wins over a simultaneous start
        cfg_blk = 9; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (ready !== 1'b1 || Init_flag !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_abort got ready=%b init=%b rv=%b exp=1 0 0", ready, Init_flag, rd_valid);
        end
    endtask

    task automatic test_abort();
        bit found = 0;
        int dones = 0, not_ready = 0;
        cfg_blk = 40; cfg_maxIter = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (rd_valid && addr_cnt == 17) found = 1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL abort_wait got=timeout exp=addr17");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (ready !== 1'b1 || rd_valid !== 1'b0 || Init_flag !== 1'b0 || done !== 1'b0 ||
            iter_cnt !== '0 || blockSize !== AW'(40)) begin
            bad++;
            $display("FAIL abort got r=%b rv=%b i=%b d=%b it=%0d blk=%0d exp 1 0 0 0 0 40",
                     ready, rd_valid, Init_flag, done, iter_cnt, blockSize);
        end
        for (int k = 0; k < 60; k++) begin
            if (done) dones++;
            if (!ready) not_ready++;
            @(negedge clk);
        end
        total++;
        if (dones !== 0 || not_ready !== 0) begin
            bad++;
            $display("FAIL abort_quiet got done=%0d busy=%0d exp 0 0", dones, not_ready);
        end
    endtask

    task automatic test_reset_in_drain();
        int inits = 0;
        cfg_blk = 5; cfg_maxIter = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);  // cycle 1 INIT, 2..6 RUN, 7..12 DRAIN
        total++;
        if (rd_valid !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset got rv=%b ready=%b exp 0 0", rd_valid, ready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (dut_vec() !== mk(1, 0, 0, 0, 0, 0, 0) || blockSize !== '0 || Req_RQ_Init !== '0) begin
            bad++;
            $display("FAIL reset_drain got=%h exp=%h", dut_vec(), mk(1, 0, 0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 20; k++) begin
            if (Init_flag) inits++;
            @(negedge clk);
        end
        total++;
        if (inits !== 0) begin
            bad++;
            $display("FAIL no_init got=%0d exp=0", inits);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int blk, mi, es_it, es_h, es_a;
            blk   = $urandom_range(1, 24);
            mi    = $urandom_range(0, 5);
            es_it = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
            es_h  = $urandom_range(0, 1);
            es_a  = $urandom_range(0, blk - 1);
            run_seq("random", blk, mi, es_it, es_h, es_a, $urandom_range(0, 2 * blk));
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        run_seq("blk40_it2", 40, 2, -1, 0, 0, -1);
        run_seq("blk1_it0", 1, 0, -1, 0, 0, -1);
        run_seq("early_stop_h1", 40, 8, 2, 1, 10, -1);
        run_seq("early_stop_h0", 40, 8, 2, 0, 10, -1);
        run_seq("start_in_run", 12, 1, -1, 0, 0, 5);
        test_cfg_err();
        test_abort();
        run_seq("after_abort", 40, 2, -1, 0, 0, -1);
        test_reset_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
